// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencer: trigger -> random hold-off -> LED/timing -> result.
// Tracks its own ms count to flag early presses (cheat) and timeouts.
module reaction_ctrl #(
    parameter int unsigned MIN_DELAY = 500,
    parameter int unsigned RAND_BITS = 11,
    parameter int unsigned TIMEOUT   = 9999,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_ms,
    input  logic        trigger,
    input  logic        response,
    output logic        start_counting,
    output logic        end_counting,
    output logic        led_on,
    output logic        busy,
    output logic        result_valid,
    output logic        timeout,
    output logic        cheat,
    output logic [15:0] elapsed_ms
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_TIMING = 3'd2,
        S_DONE   = 3'd3,
        S_CHEAT  = 3'd4
    } state_t;

    localparam logic [15:0] MIN_DELAY_W = 16'(MIN_DELAY);
    localparam logic [15:0] TIMEOUT_W   = 16'(TIMEOUT);
    localparam logic [15:0] RAND_MASK   = 16'((64'd1 << RAND_BITS) - 64'd1);
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic [15:0] delay_cnt;
    logic [15:0] delay_nxt;
    logic [15:0] elapsed_nxt;
    logic        trig_prev;
    logic        resp_prev;
    logic        trig_edge;
    logic        resp_edge;
    logic        start_nxt;
    logic        end_nxt;
    logic        led_nxt;
    logic        busy_nxt;
    logic        valid_nxt;
    logic        timeout_nxt;
    logic        cheat_nxt;

    assign trig_edge = trigger & ~trig_prev;
    assign resp_edge = response & ~resp_prev;

    // Right-shifting Galois LFSR; a nonzero seed keeps it out of the all-zero lock-up.
    assign lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

    always_comb begin
        state_nxt   = state;
        delay_nxt   = delay_cnt;
        elapsed_nxt = elapsed_ms;
        start_nxt   = 1'b0;
        end_nxt     = 1'b0;
        valid_nxt   = result_valid;
        timeout_nxt = timeout;
        cheat_nxt   = cheat;

        case (state)
            S_IDLE, S_DONE, S_CHEAT: begin
                // A response edge coinciding with the trigger is simply ignored here.
                if (trig_edge) begin
                    state_nxt   = S_ARM;
                    delay_nxt   = MIN_DELAY_W + (lfsr & RAND_MASK);
                    valid_nxt   = 1'b0;
                    timeout_nxt = 1'b0;
                    cheat_nxt   = 1'b0;
                end
            end

            S_ARM: begin
                if (resp_edge) begin
                    state_nxt = S_CHEAT;
                    cheat_nxt = 1'b1;
                end else if (tick_ms) begin
                    delay_nxt = delay_cnt - 16'd1;
                    if (delay_cnt <= 16'd1) begin
                        state_nxt   = S_TIMING;
                        delay_nxt   = 16'd0;
                        elapsed_nxt = 16'd0;
                        start_nxt   = 1'b1;
                    end
                end
            end

            S_TIMING: begin
                if (resp_edge) begin
                    state_nxt   = S_DONE;
                    end_nxt     = 1'b1;
                    valid_nxt   = 1'b1;
                    timeout_nxt = 1'b0;
                end else if (tick_ms) begin
                    elapsed_nxt = elapsed_ms + 16'd1;
                    if (elapsed_ms >= TIMEOUT_W - 16'd1) begin
                        elapsed_nxt = TIMEOUT_W;
                        state_nxt   = S_DONE;
                        end_nxt     = 1'b1;
                        valid_nxt   = 1'b1;
                        timeout_nxt = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        led_nxt  = (state_nxt == S_TIMING);
        busy_nxt = (state_nxt == S_ARM) || (state_nxt == S_TIMING);
    end

    // Every output is a flop so the LED and strobes are glitch-free and aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            lfsr           <= LFSR_SEED;
            delay_cnt      <= 16'd0;
            elapsed_ms     <= 16'd0;
            trig_prev      <= 1'b0;
            resp_prev      <= 1'b0;
            start_counting <= 1'b0;
            end_counting   <= 1'b0;
            led_on         <= 1'b0;
            busy           <= 1'b0;
            result_valid   <= 1'b0;
            timeout        <= 1'b0;
            cheat          <= 1'b0;
        end else begin
            state          <= state_nxt;
            lfsr           <= lfsr_nxt;
            delay_cnt      <= delay_nxt;
            elapsed_ms     <= elapsed_nxt;
            trig_prev      <= trigger;
            resp_prev      <= response;
            start_counting <= start_nxt;
            end_counting   <= end_nxt;
            led_on         <= led_nxt;
            busy           <= busy_nxt;
            result_valid   <= valid_nxt;
            timeout        <= timeout_nxt;
            cheat          <= cheat_nxt;
        end
    end

endmodule
